bus_stream_producer: RTL and testbench

- Active transmit end of the `bus` interface (`valid`/`data`, no backpressure). Stands in for the constant-driving producer stub.
- A local source pushes words into an internal FIFO. The block drains the FIFO onto `bus_if` at most one word per cycle, with a programmable idle gap between words.
- The consumer side samples `bus_if.valid` and `bus_if.data` on `posedge i_clk` unchanged.

---
 rtl/bus_stream_producer_if.sv | 20 ++
 rtl/bus_stream_producer.sv | 172 +++++++++++++++++
 tb/tb_bus_stream_producer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_stream_producer_if.sv
// ============================================================================
// Module   : bus (interface)
// Brief    : Simple valid/data stream bus with no backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus #(
    parameter int p_width = 32
) (
    input logic clk
);
    logic               valid;
    logic [p_width-1:0] data;

    modport producer (input clk, output valid, output data);
    modport consumer (input clk, input valid, input data);
endinterface

`default_nettype wire

// File: rtl/bus_stream_producer.sv
// ============================================================================
// Module   : bus_stream_producer
// Brief    : FIFO-buffered transmitter driving a bus interface with a
//            programmable idle gap between words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_stream_producer #(
    parameter int p_width = 32,
    parameter int p_depth = 8,
    parameter int p_gap_w = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [p_width-1:0]         i_data,
    input  logic                       i_enable,
    input  logic [p_gap_w-1:0]         i_gap,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(p_depth):0]   o_level,
    output logic                       o_overflow,
    bus.producer                       bus_if
);

    localparam int c_AW = $clog2(p_depth);

    localparam logic [c_AW:0]        c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW:0]        c_DEPTH   = c_PTR_ONE << c_AW;
    localparam logic [p_gap_w-1:0]   c_GAP_ONE = {{(p_gap_w-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [p_width-1:0] r_mem [p_depth];
    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic [c_AW:0]      r_level;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;

    logic [1:0]         r_state;
    logic [p_gap_w-1:0] r_gap_cnt;
    logic               r_valid;
    logic [p_width-1:0] r_data;

    logic               w_pop;
    logic               w_push;
    logic [c_AW:0]      w_level_nxt;
    logic [p_width-1:0] w_head;

    assign w_head = r_mem[r_rptr[c_AW-1:0]];

    // The gap expiry cycle may issue the next word directly, so a gap of g
    // yields exactly g idle cycles between words.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            c_IDLE:  w_pop = i_enable && !r_empty;
            c_SEND:  w_pop = (i_gap == '0) && i_enable && !r_empty;
            c_GAP:   w_pop = (r_gap_cnt == '0) && i_enable && !r_empty;
            default: w_pop = 1'b0;
        endcase
    end

    assign w_push = i_push && (!r_full || w_pop);

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_PTR_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (i_push && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_DEPTH);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_IDLE;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_data  <= w_head;
                        r_valid <= 1'b1;
                        r_state <= c_SEND;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                c_SEND: begin
                    if (w_pop) begin
                        r_data  <= w_head;
                        r_valid <= 1'b1;
                    end else if (i_gap != '0) begin
                        r_valid   <= 1'b0;
                        r_gap_cnt <= i_gap - c_GAP_ONE;
                        r_state   <= c_GAP;
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                c_GAP: begin
                    if (r_gap_cnt == '0) begin
                        if (w_pop) begin
                            r_data  <= w_head;
                            r_valid <= 1'b1;
                            r_state <= c_SEND;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_valid   <= 1'b0;
                        r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus_if.valid = r_valid;
    assign bus_if.data  = r_data;
    assign o_full       = r_full;
    assign o_empty      = r_empty;
    assign o_level      = r_level;
    assign o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bus_stream_producer.sv
// ============================================================================
// Module   : tb_bus_stream_producer
// Brief    : Self-checking bench for bus_stream_producer with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_stream_producer;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int GW = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic          enable = 1'b0;
    logic [W-1:0]  data = '0;
    logic [GW-1:0] gap = '0;
    logic          full;
    logic          empty;
    logic          over;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    bus #(.p_width(W)) u_bus (.clk(clk));

    bus_stream_producer #(.p_width(W), .p_depth(D), .p_gap_w(GW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_push     (push),
        .i_data     (data),
        .i_enable   (enable),
        .i_gap      (gap),
        .o_full     (full),
        .o_empty    (empty),
        .o_level    (level),
        .o_overflow (over),
        .bus_if     (u_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word queue plus the earliest edge at which the next word may go out.
    logic [W-1:0] mq[$];
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    bit           m_over  = 1'b0;
    int           cyc     = 0;
    int           next_ok = 0;
    int           m_pre;
    bit           m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_over  = 1'b0;
            cyc     = 0;
            next_ok = 0;
        end else begin
            cyc++;
            m_pre = mq.size();
            if (m_valid && gap != '0) next_ok = cyc + int'(gap);
            m_pop = enable && (m_pre > 0) && (cyc >= next_ok);
            if (m_pop) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (push) begin
                if (m_pre < D || m_pop) mq.push_back(data);
                else m_over = 1'b1;
            end
        end
    end

    bit           cap = 1'b0;
    bit           vhist[$];
    logic [W-1:0] dhist[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid",    64'(u_bus.valid), 64'(m_valid));
            chk("data",     64'(u_bus.data),  64'(m_data));
            chk("level",    64'(level),       64'(mq.size()));
            chk("full",     64'(full),        64'(mq.size() == D));
            chk("empty",    64'(empty),       64'(mq.size() == 0));
            chk("overflow", 64'(over),        64'(m_over));
            if (cap) begin
                vhist.push_back(u_bus.valid);
                if (u_bus.valid) dhist.push_back(u_bus.data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; push = 1'b0; enable = 1'b0; gap = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_words(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push = 1'b1;
            data = base + W'(i);
            @(negedge clk);
        end
        push = 1'b0;
    endtask

    task automatic start_cap();
        vhist.delete();
        dhist.delete();
        @(posedge clk);
        #1 cap = 1'b1;
    endtask

    bit           exp_v2[7]  = '{0, 1, 1, 1, 0, 0, 0};
    bit           exp_v3[10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic [W-1:0] exp_d2[3]  = '{32'h11, 32'h22, 32'h33};
    int           ones;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_valid", 64'(u_bus.valid), 64'd0);
        chk("rst_data",  64'(u_bus.data),  64'd0);
        chk("rst_empty", 64'(empty),       64'd1);
        chk("rst_level", 64'(level),       64'd0);
        repeat (20) @(negedge clk);
        chk("idle_valid", 64'(u_bus.valid), 64'd0);
        chk("idle_level", 64'(level),       64'd0);

        // Three back-to-back words with no gap
        gap = '0; enable = 1'b1; push = 1'b1; data = 32'h11;
        start_cap();
        @(negedge clk); data = 32'h22;
        @(negedge clk); data = 32'h33;
        @(negedge clk); push = 1'b0;
        repeat (4) @(negedge clk);
        #1 cap = 1'b0;
        chk("b2b_vlen", 64'(vhist.size()), 64'd7);
        for (int i = 0; i < 7 && i < vhist.size(); i++) chk("b2b_vpat", 64'(vhist[i]), 64'(exp_v2[i]));
        chk("b2b_dlen", 64'(dhist.size()), 64'd3);
        for (int i = 0; i < 3 && i < dhist.size(); i++) chk("b2b_data", 64'(dhist[i]), 64'(exp_d2[i]));
        chk("b2b_empty", 64'(empty), 64'd1);

        // Gap of 2, with a mid-gap change to 0 that must not shorten it
        enable = 1'b0; gap = 4'd2;
        push_words(32'hA0, 4);
        enable = 1'b1;
        start_cap();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) gap = '0;
            if (i == 2) gap = 4'd2;
        end
        #1 cap = 1'b0;
        chk("gap_vlen", 64'(vhist.size()), 64'd10);
        for (int i = 0; i < 10 && i < vhist.size(); i++) chk("gap_vpat", 64'(vhist[i]), 64'(exp_v3[i]));
        chk("gap_dlen", 64'(dhist.size()), 64'd4);
        for (int i = 0; i < 4 && i < dhist.size(); i++) chk("gap_data", 64'(dhist[i]), 64'(32'hA0 + i));

        // Overflow: nine pushes into a depth-8 FIFO while disabled
        do_reset();
        gap = '0; enable = 1'b0;
        push_words(32'hB0, 9);
        chk("ovf_full",  64'(full),  64'd1);
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_flag",  64'(over),  64'd1);
        enable = 1'b1;
        start_cap();
        repeat (16) @(negedge clk);
        #1 cap = 1'b0;
        chk("ovf_dlen", 64'(dhist.size()), 64'd8);
        for (int i = 0; i < 8 && i < dhist.size(); i++) chk("ovf_data", 64'(dhist[i]), 64'(32'hB0 + i));

        // Full FIFO with simultaneous push and pop
        do_reset();
        enable = 1'b0;
        push_words(32'hC0, 8);
        enable = 1'b1; push = 1'b1; data = 32'hD0;
        @(negedge clk);
        push = 1'b0;
        chk("pp_level", 64'(level),       64'd8);
        chk("pp_full",  64'(full),        64'd1);
        chk("pp_ovf",   64'(over),        64'd0);
        chk("pp_valid", 64'(u_bus.valid), 64'd1);
        chk("pp_data",  64'(u_bus.data),  64'hC0);
        repeat (12) @(negedge clk);

        // Asynchronous reset while a word is on the bus and three are queued
        enable = 1'b0; gap = 4'd3;
        push_words(32'hE0, 4);
        enable = 1'b1;
        @(negedge clk);
        chk("mr_pre_valid", 64'(u_bus.valid), 64'd1);
        chk("mr_pre_level", 64'(level),       64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(u_bus.valid), 64'd0);
        chk("mr_level", 64'(level),       64'd0);
        chk("mr_empty", 64'(empty),       64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_cap();
        repeat (10) @(negedge clk);
        #1 cap = 1'b0;
        ones = 0;
        foreach (vhist[i]) if (vhist[i]) ones++;
        chk("mr_silent", 64'(ones), 64'd0);
        push_words(32'hF0, 1);
        repeat (4) @(negedge clk);

        // Randomized traffic against the model
        gap = '0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            push   = ($urandom_range(0, 2) != 0);
            data   = $urandom;
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) gap = GW'($urandom_range(0, 3));
        end
        @(negedge clk);
        push = 1'b0; enable = 1'b1;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
